// File: rtl/fifo_ctrl_pkg.sv
// Shared types and constants for the 1024x8 first-word-fall-through FIFO.
package fifo_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH = 1024;
    localparam int unsigned FIFO_AW    = 10;
    localparam int unsigned FIFO_DW    = 8;
    localparam int unsigned FIFO_CW    = 11;
    localparam int unsigned OBUF_DEPTH = 2;

    typedef logic [FIFO_AW-1:0] addr_t;
    typedef logic [FIFO_DW-1:0] data_t;
    typedef logic [FIFO_CW-1:0] cnt_t;
    typedef logic [1:0]         bcnt_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } flags_t;

    localparam flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

    // Status flags for a given total occupancy.
    function automatic flags_t calc_flags(cnt_t c, cnt_t af_th, cnt_t ae_th);
        flags_t f;
        f.full   = (c == cnt_t'(FIFO_DEPTH));
        f.empty  = (c == '0);
        f.afull  = (c >= af_th);
        f.aempty = (c <= ae_th);
        return f;
    endfunction

endpackage

// File: rtl/dpram_1024x8.sv
// Simple dual-port 1024x8 RAM: one write port, one registered read port (1-cycle latency).
module dpram_1024x8
    import fifo_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  wen,
    input  addr_t waddr,
    input  data_t data_in,
    input  logic  ren,
    input  addr_t raddr,
    output data_t data_out
);

    data_t mem [FIFO_DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (wen) begin
            mem[waddr] <= data_in;
        end
    end

    // Registered read port.
    always_ff @(posedge clk) begin
        if (ren) begin
            data_out <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_obuf_2x8.sv
// Two-entry output prefetch buffer; entry 0 is the FIFO head.
module fifo_obuf_2x8
    import fifo_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  cap_i,
    input  data_t cap_data_i,
    input  logic  pop_i,
    output data_t head_o,
    output bcnt_t cnt_o
);

    data_t ent0_q, ent0_d;
    data_t ent1_q, ent1_d;
    bcnt_t cnt_q, cnt_d;
    bcnt_t cnt_pop;

    // Shift on pop first, then place the captured word at the resulting tail.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        cnt_pop = cnt_q;
        if (pop_i) begin
            ent0_d  = ent1_q;
            cnt_pop = cnt_q - 2'd1;
        end
        if (cap_i) begin
            if (cnt_pop == 2'd0) begin
                ent0_d = cap_data_i;
            end else begin
                ent1_d = cap_data_i;
            end
        end
        cnt_d = cnt_pop + bcnt_t'(cap_i);
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= '0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign head_o = ent0_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/fifo_ctrl_1024x8.sv
// 1024x8 first-word-fall-through FIFO around dpram_1024x8 with a 2-entry prefetch buffer.
// Optional macro FIFO_LEVEL_EN adds the 'level' port (registered total count).
module fifo_ctrl_1024x8
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned AF_THRESH = 1020,
    parameter int unsigned AE_THRESH = 4
) (
    input  logic        clk,
    input  logic        RN,
    input  logic [7:0]  push_data,
    input  logic        push_valid,
    output logic        push_ready,
    output logic [7:0]  pop_data,
    output logic        pop_valid,
    input  logic        pop_ready,
    output logic        full,
    output logic        empty,
    output logic        almost_full,
    output logic        almost_empty
`ifdef FIFO_LEVEL_EN
    ,
    output logic [10:0] level
`endif
);

    localparam cnt_t AF_C = cnt_t'(AF_THRESH);
    localparam cnt_t AE_C = cnt_t'(AE_THRESH);

    addr_t  wptr_q, wptr_d;
    addr_t  rptr_q, rptr_d;
    cnt_t   mem_cnt_q, mem_cnt_d;
    cnt_t   cnt_q, cnt_d;
    logic   rd_pend_q, rd_pend_d;
    flags_t flags_q, flags_d;

    logic       push_fire;
    logic       pop_fire;
    logic       fetch;
    logic [2:0] occ;
    bcnt_t      buf_cnt;
    data_t      ram_rdata;
    data_t      head;

    // Handshakes, fetch decision, pointer/count next state and flags from the next count.
    always_comb begin
        push_fire = push_valid && !flags_q.full;
        pop_fire  = (buf_cnt != '0) && pop_ready;
        // Words buffered or in flight after this cycle's pop; fetch only if one slot stays free.
        occ       = 3'(buf_cnt) + 3'(rd_pend_q) - 3'(pop_fire);
        fetch     = (mem_cnt_q != '0) && (occ < 3'd2);
        wptr_d    = wptr_q + addr_t'(push_fire);
        rptr_d    = rptr_q + addr_t'(fetch);
        mem_cnt_d = mem_cnt_q + cnt_t'(push_fire) - cnt_t'(fetch);
        cnt_d     = cnt_q + cnt_t'(push_fire) - cnt_t'(pop_fire);
        rd_pend_d = fetch;
        flags_d   = calc_flags(cnt_d, AF_C, AE_C);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge RN) begin
        if (!RN) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            mem_cnt_q <= '0;
            cnt_q     <= '0;
            rd_pend_q <= 1'b0;
            flags_q   <= FLAGS_RST;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            mem_cnt_q <= mem_cnt_d;
            cnt_q     <= cnt_d;
            rd_pend_q <= rd_pend_d;
            flags_q   <= flags_d;
        end
    end

    dpram_1024x8 u_ram (
        .clk      (clk),
        .wen      (push_fire),
        .waddr    (wptr_q),
        .data_in  (push_data),
        .ren      (fetch),
        .raddr    (rptr_q),
        .data_out (ram_rdata)
    );

    fifo_obuf_2x8 u_obuf (
        .clk        (clk),
        .rst_n      (RN),
        .cap_i      (rd_pend_q),
        .cap_data_i (ram_rdata),
        .pop_i      (pop_fire),
        .head_o     (head),
        .cnt_o      (buf_cnt)
    );

    assign push_ready   = !flags_q.full;
    assign pop_valid    = (buf_cnt != '0);
    assign pop_data     = head;
    assign full         = flags_q.full;
    assign empty        = flags_q.empty;
    assign almost_full  = flags_q.afull;
    assign almost_empty = flags_q.aempty;
`ifdef FIFO_LEVEL_EN
    assign level        = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_ctrl_1024x8.sv
// Self-checking bench for fifo_ctrl_1024x8 (scoreboard of pushed words plus occupancy model).
`timescale 1ns/1ps
module tb_fifo_ctrl_1024x8;

    logic        clk = 1'b0;
    logic        RN = 1'b0;
    logic [7:0]  push_data = 8'h00;
    logic        push_valid = 1'b0;
    logic        pop_ready = 1'b0;
    logic        push_ready;
    logic [7:0]  pop_data;
    logic        pop_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
`ifdef FIFO_LEVEL_EN
    logic [10:0] level;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  sb_q[$];
    int          mdl_cnt = 0;

    fifo_ctrl_1024x8 #(.AF_THRESH(1020), .AE_THRESH(4)) dut (
        .clk          (clk),
        .RN           (RN),
        .push_data    (push_data),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .pop_data     (pop_data),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef FIFO_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    always #5 clk = ~clk;

    // Scoreboard and occupancy model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [7:0] exp_d;
        if (!RN) begin
            sb_q.delete();
            mdl_cnt = 0;
        end else begin
            n_cmp++;
            if (full !== (mdl_cnt == 1024) || empty !== (mdl_cnt == 0) ||
                almost_full !== (mdl_cnt >= 1020) || almost_empty !== (mdl_cnt <= 4) ||
                push_ready !== (mdl_cnt != 1024) || (mdl_cnt == 0 && pop_valid !== 1'b0)) begin
                n_err++;
                $display("FAIL flags: count=%0d got full=%b empty=%b af=%b ae=%b push_ready=%b pop_valid=%b",
                         mdl_cnt, full, empty, almost_full, almost_empty, push_ready, pop_valid);
            end
`ifdef FIFO_LEVEL_EN
            n_cmp++;
            if (level !== 11'(mdl_cnt)) begin
                n_err++;
                $display("FAIL level: got %0d required %0d", level, mdl_cnt);
            end
`endif
            if (push_valid && push_ready) begin
                sb_q.push_back(push_data);
                mdl_cnt++;
            end
            if (pop_valid && pop_ready) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_underflow: got %h with nothing expected", pop_data);
                end else begin
                    exp_d = sb_q.pop_front();
                    if (pop_data !== exp_d) begin
                        n_err++;
                        $display("FAIL pop_data: got %h required %h", pop_data, exp_d);
                    end
                end
                mdl_cnt--;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_fifo(output bit timed_out);
        push_valid = 1'b0;
        pop_ready  = 1'b1;
        timed_out  = 1'b1;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (empty === 1'b1 && pop_valid === 1'b0) begin
                timed_out = 1'b0;
                break;
            end
        end
        cyc();
        pop_ready = 1'b0;
    endtask

    task automatic test_reset();
        RN = 1'b0;
        push_valid = 1'b0;
        pop_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({pop_data, pop_valid, push_ready, full, empty, almost_full, almost_empty} !==
            {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_state: got data=%h pv=%b pr=%b f=%b e=%b af=%b ae=%b required 00 0 1 0 1 0 1",
                     pop_data, pop_valid, push_ready, full, empty, almost_full, almost_empty);
        end
`ifdef FIFO_LEVEL_EN
        n_cmp++;
        if (level !== 11'd0) begin
            n_err++;
            $display("FAIL reset_level: got %0d required 0", level);
        end
`endif
        RN = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        push_data = 8'hA5;
        push_valid = 1'b1;
        pop_ready = 1'b1;
        @(posedge clk);
        #1;
        push_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (pop_valid !== 1'b0) begin n_err++; $display("FAIL lat_e0: pop_valid got %b required 0", pop_valid); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (pop_valid !== 1'b0) begin n_err++; $display("FAIL lat_e1: pop_valid got %b required 0", pop_valid); end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (pop_valid !== 1'b1 || pop_data !== 8'hA5) begin
            n_err++;
            $display("FAIL lat_e2: got pv=%b data=%h required pv=1 data=a5", pop_valid, pop_data);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (empty !== 1'b1 || pop_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_empty: got empty=%b pv=%b required 1 0", empty, pop_valid);
        end
        cyc();
        pop_ready = 1'b0;
    endtask

    task automatic test_fill();
        bit to;
        pop_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            push_data = 8'(i);
            push_valid = 1'b1;
            cyc();
        end
        push_valid = 1'b0;
        n_cmp++;
        if (full !== 1'b1 || push_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_after_1024: got full=%b push_ready=%b required 1 0", full, push_ready);
        end
        push_data = 8'hFF;
        push_valid = 1'b1;
        cyc();
        push_valid = 1'b0;
        n_cmp++;
        if (full !== 1'b1 || push_ready !== 1'b0) begin
            n_err++;
            $display("FAIL refused_push: got full=%b push_ready=%b required 1 0", full, push_ready);
        end
        drain_fifo(to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL fill_drain: empty got 0 required 1 within bound"); end
    endtask

    task automatic test_full_stream();
        bit to;
        int d = 0;
        int full_cycles = 0;
        bit fire;
        pop_ready = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            push_data = 8'(d);
            push_valid = 1'b1;
            cyc();
            d++;
        end
        pop_ready = 1'b1;
        for (int t = 0; t < 2000; t++) begin
            push_data = 8'(d);
            push_valid = 1'b1;
            @(negedge clk);
            fire = push_valid && push_ready;
            if (full === 1'b1) full_cycles++;
            cyc();
            if (fire) d++;
        end
        n_cmp++;
        if (d != 3023) begin n_err++; $display("FAIL stream_accepts: got %0d required 3023", d); end
        n_cmp++;
        if (full_cycles != 1) begin n_err++; $display("FAIL stream_full_cycles: got %0d required 1", full_cycles); end
        drain_fifo(to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL stream_drain: empty got 0 required 1 within bound"); end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit exp_v;
        int s;
        pop_ready = 1'b1;
        for (int t = 0; t <= 506; t++) begin
            push_valid = (t < 500);
            push_data = 8'(t + 7);
            @(negedge clk);
            s = t - 1;
            exp_v = (s >= 2 && s <= 501);
            n_cmp++;
            if (pop_valid !== exp_v) begin
                n_err++;
                $display("FAIL b2b_pop_valid: cycle %0d got %b required %b", t, pop_valid, exp_v);
            end
            cyc();
        end
        drain_fifo(to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL b2b_drain: empty got 0 required 1 within bound"); end
    endtask

    task automatic test_thresholds();
        bit to;
        pop_ready = 1'b0;
        for (int i = 1; i <= 1020; i++) begin
            push_data = 8'(i);
            push_valid = 1'b1;
            cyc();
            if (i == 4 || i == 5 || i == 1019 || i == 1020) begin
                n_cmp++;
                if (almost_empty !== (i <= 4) || almost_full !== (i >= 1020)) begin
                    n_err++;
                    $display("FAIL thresh_%0d: got af=%b ae=%b required af=%b ae=%b",
                             i, almost_full, almost_empty, (i >= 1020), (i <= 4));
                end
`ifdef FIFO_LEVEL_EN
                n_cmp++;
                if (level !== 11'(i)) begin
                    n_err++;
                    $display("FAIL thresh_level: got %0d required %0d", level, i);
                end
`endif
            end
        end
        push_valid = 1'b0;
        drain_fifo(to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL thresh_drain: empty got 0 required 1 within bound"); end
    endtask

    task automatic test_reset_mid();
        bit got;
        pop_ready = 1'b0;
        for (int i = 0; i < 38; i++) begin
            push_data = 8'(8'h80 + i);
            push_valid = 1'b1;
            cyc();
        end
        push_valid = 1'b0;
        repeat (3) cyc();
        // One pop leaves count 37 with a refill read in flight.
        pop_ready = 1'b1;
        cyc();
        pop_ready = 1'b0;
        #1;
        RN = 1'b0;
        #1;
        n_cmp++;
        if ({pop_data, pop_valid, push_ready, full, empty, almost_full, almost_empty} !==
            {8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL async_reset: got data=%h pv=%b pr=%b f=%b e=%b af=%b ae=%b required 00 0 1 0 1 0 1",
                     pop_data, pop_valid, push_ready, full, empty, almost_full, almost_empty);
        end
`ifdef FIFO_LEVEL_EN
        n_cmp++;
        if (level !== 11'd0) begin n_err++; $display("FAIL async_reset_level: got %0d required 0", level); end
`endif
        @(posedge clk);
        #1;
        RN = 1'b1;
        cyc();
        push_data = 8'h3C;
        push_valid = 1'b1;
        pop_ready = 1'b1;
        cyc();
        push_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (pop_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!got || pop_data !== 8'h3C) begin
            n_err++;
            $display("FAIL post_reset_data: got pv=%b data=%h required pv=1 data=3c", got, pop_data);
        end
        repeat (2) cyc();
        n_cmp++;
        if (empty !== 1'b1 || pop_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_empty: got empty=%b pv=%b required 1 0", empty, pop_valid);
        end
        pop_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_full_stream();
        test_back_to_back();
        test_thresholds();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
